// File: rtl/imem_dual_responder.sv
// Two-bank, word-interleaved instruction memory with combinational dual read ports
// and a valid/ready loader that stalls the core until an image has been written.
module imem_dual_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    imem_addr0,
    input  logic [31:0]                    imem_addr1,
    output logic [31:0]                    imem_data0,
    output logic [31:0]                    imem_data1,
    input  logic                           load_valid,
    input  logic [31:0]                    load_data,
    input  logic                           load_last,
    output logic                           load_ready,
    input  logic                           reload,
    output logic                           core_stall,
    output logic [$clog2(DEPTH_WORDS):0]   loaded_words,
    output logic                           misalign_err,
    output logic                           bank_conflict
);
    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int ROWS = DEPTH_WORDS / 2;

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_wptr;
    logic [AW:0]     r_loaded;
    logic            r_misalign;
    logic [31:0]     r_bank0 [ROWS];
    logic [31:0]     r_bank1 [ROWS];

    logic            w_run;
    logic            w_xfer;
    logic            w_load_done;
    logic            w_ok0;
    logic            w_ok1;
    logic            w_conflict;
    logic [AW-2:0]   w_row0;
    logic [AW-2:0]   w_row1;
    logic [31:0]     w_rd0;
    logic [31:0]     w_rd1;

    assign w_run       = (r_state == ST_RUN);
    assign w_xfer      = load_valid && (r_state == ST_LOAD);
    assign w_load_done = w_xfer && (load_last || (r_wptr == AW'(DEPTH_WORDS - 1)));

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_next     = r_state;
        load_ready = 1'b0;
        core_stall = 1'b0;
        case (r_state)
            ST_LOAD: begin
                load_ready = 1'b1;
                core_stall = 1'b1;
                if (w_load_done) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (reload) w_next = ST_LOAD;
            end
            default: w_next = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_LOAD;
            r_wptr     <= '0;
            r_loaded   <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_run && reload) begin
                r_wptr   <= '0;
                r_loaded <= '0;
            end else if (w_xfer) begin
                r_wptr   <= r_wptr + 1'b1;
                r_loaded <= r_loaded + 1'b1;
            end
            if (w_run && ((imem_addr0[1:0] != 2'b00) || (imem_addr1[1:0] != 2'b00)))
                r_misalign <= 1'b1;
        end
    end

    // NOTE: the storage arrays have no reset; a reset mid-load deliberately leaves the partial image in place.
    always_ff @(posedge clk) begin
        if (reset && w_xfer) begin
            if (r_wptr[0]) r_bank1[r_wptr[AW-1:1]] <= load_data;
            else           r_bank0[r_wptr[AW-1:1]] <= load_data;
        end
    end

    // Word index is addr[31:2]; its low bit picks the bank and the rest is the row.
    assign w_row0 = imem_addr0[AW+1:3];
    assign w_row1 = imem_addr1[AW+1:3];
    assign w_rd0  = imem_addr0[2] ? r_bank1[w_row0] : r_bank0[w_row0];
    assign w_rd1  = imem_addr1[2] ? r_bank1[w_row1] : r_bank0[w_row1];

    assign w_ok0 = w_run && (imem_addr0[1:0] == 2'b00) && (imem_addr0[31:AW+2] == '0);
    assign w_ok1 = w_run && (imem_addr1[1:0] == 2'b00) && (imem_addr1[31:AW+2] == '0);
    assign w_conflict = w_ok0 && w_ok1 && (imem_addr0[2] == imem_addr1[2]);

    assign imem_data0    = w_ok0 ? w_rd0 : NOP_WORD;
    assign imem_data1    = (w_ok1 && !w_conflict) ? w_rd1 : NOP_WORD;
    assign bank_conflict = w_conflict;
    assign loaded_words  = r_loaded;
    assign misalign_err  = r_misalign;
endmodule

// File: tb/tb_imem_dual_responder.sv
// Self-checking bench: loads images, reads them back through a scoreboard of
// expected fetch results, and checks stall/loader/error handshakes.
module tb_imem_dual_responder;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr0, imem_addr1, imem_data0, imem_data1;
    logic        load_valid, load_last, load_ready, reload, core_stall;
    logic [31:0] load_data;
    logic [4:0]  loaded_words;
    logic        misalign_err, bank_conflict;

    imem_dual_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset),
        .imem_addr0(imem_addr0), .imem_addr1(imem_addr1),
        .imem_data0(imem_data0), .imem_data1(imem_data1),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .reload(reload), .core_stall(core_stall),
        .loaded_words(loaded_words), .misalign_err(misalign_err),
        .bank_conflict(bank_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
    } rd_exp_t;

    rd_exp_t     sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] a_img [4];
    logic [31:0] f_img [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(posedge clk);
        #1 load_valid = 1'b0;
        load_last = 1'b0;
    endtask

    task automatic do_reload(input logic with_valid);
        @(negedge clk);
        reload     = 1'b1;
        load_valid = with_valid;
        load_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 reload = 1'b0;
        load_valid = 1'b0;
    endtask

    // Drive a fetch pair, record what must come back, then compare once settled.
    task automatic fetch(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1);
        rd_exp_t e;
        @(negedge clk);
        imem_addr0 = a0;
        imem_addr1 = a1;
        sb.push_back('{tag, e0, e1});
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_d0"}, imem_data0, e.d0);
            check({e.tag, "_d1"}, imem_data1, e.d1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++)     a_img[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < DEPTH; i++) f_img[i] = 32'hF000_0100 + 32'(i * 3);
        reset = 1'b0; reload = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = '0; imem_addr0 = 32'd0; imem_addr1 = 32'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",    32'(load_ready),    32'd1);
        check("rst_stall",    32'(core_stall),    32'd1);
        check("rst_d0",       imem_data0,         NOP);
        check("rst_d1",       imem_data1,         NOP);
        check("rst_loaded",   32'(loaded_words),  32'd0);
        check("rst_misalign", 32'(misalign_err),  32'd0);
        check("rst_conflict", 32'(bank_conflict), 32'd0);
        reset = 1'b1;

        // Short image with a 3-cycle gap in the stream.
        load_word(a_img[0], 1'b0);
        load_word(a_img[1], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gap_d0",     imem_data0,        NOP);
            check("gap_stall",  32'(core_stall),   32'd1);
            check("gap_loaded", 32'(loaded_words), 32'd2);
        end
        load_word(a_img[2], 1'b0);
        check("pre_last_stall", 32'(core_stall), 32'd1);
        load_word(a_img[3], 1'b1);
        check("run_stall",  32'(core_stall),   32'd0);
        check("run_ready",  32'(load_ready),   32'd0);
        check("run_loaded", 32'(loaded_words), 32'd4);
        fetch("pc0", 32'd0, 32'd4, a_img[0], a_img[1]);
        check("pc0_conflict", 32'(bank_conflict), 32'd0);
        fetch("pc8", 32'd8, 32'd12, a_img[2], a_img[3]);

        fetch("conflict", 32'd0, 32'd8, a_img[0], NOP);
        check("conflict_flag", 32'(bank_conflict), 32'd1);

        fetch("oor", 32'd0, 32'(4 * DEPTH), a_img[0], NOP);
        check("oor_conflict", 32'(bank_conflict), 32'd0);
        @(posedge clk); #1;
        check("oor_no_err", 32'(misalign_err), 32'd0);

        fetch("misalign", 32'd2, 32'd4, NOP, a_img[1]);
        check("misalign_pre", 32'(misalign_err), 32'd0);
        @(posedge clk); #1;
        check("misalign_set", 32'(misalign_err), 32'd1);
        imem_addr0 = 32'd0;

        // Reload with a simultaneous valid word: only the state change may happen.
        do_reload(1'b1);
        check("reload_stall",    32'(core_stall),   32'd1);
        check("reload_ready",    32'(load_ready),   32'd1);
        check("reload_loaded",   32'(loaded_words), 32'd0);
        check("reload_misalign", 32'(misalign_err), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("full_pre_stall", 32'(core_stall), 32'd1);
            load_word(f_img[i], 1'b0);
        end
        check("full_stall",  32'(core_stall),   32'd0);
        check("full_loaded", 32'(loaded_words), 32'd16);
        fetch("full_last",  32'(4 * (DEPTH - 1)), 32'd0, f_img[DEPTH-1], f_img[0]);
        fetch("full_first", 32'd0, 32'd4, f_img[0], f_img[1]);

        do_reload(1'b0);
        load_word(32'hB000_0000, 1'b0);
        load_word(32'hB000_0001, 1'b1);
        fetch("b_pair", 32'd0, 32'd4, 32'hB000_0000, 32'hB000_0001);
        fetch("b_keep", 32'd8, 32'd12, f_img[2], f_img[3]);

        // Reset in the middle of a reload, then a fresh load restarts at index 0.
        do_reload(1'b0);
        load_word(32'hC000_0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_stall",    32'(core_stall),   32'd1);
        check("mid_rst_ready",    32'(load_ready),   32'd1);
        check("mid_rst_loaded",   32'(loaded_words), 32'd0);
        check("mid_rst_misalign", 32'(misalign_err), 32'd0);
        check("mid_rst_d0",       imem_data0,        NOP);
        reset = 1'b1;
        load_word(32'hD000_0000, 1'b1);
        check("d_loaded", 32'(loaded_words), 32'd1);
        fetch("d_pair", 32'd0, 32'd4, 32'hD000_0000, 32'hB000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imem_dual_responder.md
# imem_dual_responder

Dual-read instruction memory that answers the two-wide fetch stage: for every cycle it returns the instruction words at `imem_addr0` (PC) and `imem_addr1` (PC+4) combinationally, so the fetch stage's decode register captures them on the same edge. Storage is split into two word-interleaved banks, even word index in bank 0 and odd in bank 1. A built-in loader FSM fills the memory from a valid/ready word stream after reset, or on request. While loading, the block holds the core in stall.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: total 32-bit words. Must be a power of two and at least 4. Each bank holds DEPTH_WORDS/2 words.
- `NOP_WORD`, default 32'h00000013: word returned for any read that cannot be served.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low; block resets on a rising `clk` edge while `reset`==0
- `imem_addr0`  in  32  byte address of slot-0 fetch
- `imem_addr1`  in  32  byte address of slot-1 fetch
- `imem_data0`  out  32  instruction for slot 0 (combinational)
- `imem_data1`  out  32  instruction for slot 1 (combinational)
- `load_valid`  in  1  loader word valid
- `load_data`  in  32  loader word
- `load_last`  in  1  qualifies final word of the image
- `load_ready`  out  1  loader may transfer (high only in LOAD)
- `reload`  in  1  single-cycle request to re-enter LOAD from RUN
- `core_stall`  out  1  drives fetch `stall_F`; high while not in RUN
- `loaded_words`  out  log2(DEPTH_WORDS)+1  words written by the last or current load
- `misalign_err`  out  1  sticky; set by any misaligned fetch in RUN
- `bank_conflict`  out  1  combinational; both ports address the same bank in RUN

## Operation
- FSM states:
  - LOAD: reset state. `load_ready`=1, `core_stall`=1, both data outputs forced to NOP_WORD.
  - RUN: `load_ready`=0, `core_stall`=0, reads are served.
- Transfer: a word moves on a rising edge with `load_valid`&&`load_ready`.
  - The word is written at word index `wptr`. Bank is `wptr[0]`; row is `wptr>>1`.
  - `wptr` increments and `loaded_words` increments on each transfer.
- LOAD→RUN happens on the edge of a transfer that has `load_last`=1 or `wptr`==DEPTH_WORDS-1, whichever comes first. A transfer at `wptr`==DEPTH_WORDS-1 without `load_last` still ends the load.
- RUN→LOAD happens on an edge with `reload`=1. That edge clears `wptr` and `loaded_words` to 0. `load_valid` is ignored in RUN.
- Reads in RUN, computed per port:
  - word index = addr[31:2], bank = index[0].
  - If addr[1:0]!=0, the port returns NOP_WORD and `misalign_err` sets on the next edge.
  - If index>=DEPTH_WORDS, the port returns NOP_WORD. This is not an error.
  - Otherwise the port returns the stored word.
- Bank conflict: both ports are valid and in range but target the same bank. Port 0 is served, port 1 returns NOP_WORD, and `bank_conflict`=1. An aligned PC/PC+4 pair never conflicts.
- Reset effects: FSM→LOAD, `wptr`=0, `loaded_words`=0, `misalign_err`=0. Memory contents are not reset.
- Reset values of outputs: `load_ready`=1, `core_stall`=1, `imem_data0`=`imem_data1`=NOP_WORD, `loaded_words`=0, `misalign_err`=0, `bank_conflict`=0.

## Timing
- Read latency is 0 cycles: data is combinational from the address ports and stored contents.
- A write on edge N is readable from cycle N+1.
- Leaving LOAD on edge N: `core_stall` and `load_ready` fall in cycle N+1, and real data is returned from cycle N+1.
- `reload` on edge N: `core_stall` and `load_ready` rise in cycle N+1.
- `misalign_err` is registered: it rises one cycle after the misaligned cycle and holds until reset. It is not cleared by `reload`.
- Reset asserted mid-load: the partial image stays in memory. The next load restarts at index 0 and overwrites from the beginning.
- `reload` and `load_valid` on the same RUN edge: only the state change happens, and no word is written.

## Test plan
- Load 4 words A0..A3 with `load_last` on A3, then fetch addr0=0, addr1=4. Required: `imem_data0`=A0, `imem_data1`=A1, `core_stall`=0 one cycle after the A3 edge, `loaded_words`=4.
- During LOAD, drive addr0=0. Required: data=32'h00000013 and `core_stall`=1. Deassert `load_valid` for 3 cycles mid-stream. Required: no write occurs and `wptr` holds.
- Load DEPTH_WORDS words with `load_last` never asserted. Required: RUN entered on the final transfer, and the last word is readable at byte address 4*(DEPTH_WORDS-1).
- In RUN, drive addr0=2. Required: `imem_data0`=NOP and `misalign_err`=1 the next cycle. Drive addr1=4*DEPTH_WORDS. Required: NOP and no error.
- In RUN, drive addr0=0, addr1=8. Required: `bank_conflict`=1, port 0 returns word 0, port 1 returns NOP.
- Pulse `reload`, load 2 words B0,B1, then pull `reset` low mid-second-load after 1 word. Required: FSM returns to LOAD, `loaded_words`=0, `misalign_err`=0, `core_stall`=1.
